// File: rtl/spi_cmd_ctrl.sv
// Command/burst controller behind an SPI slave: decodes the command byte and
// turns the following bytes into register write strobes or read-and-return cycles.
module spi_cmd_ctrl #(
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned AUTO_INC  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_active,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic [7:0] tx_data,
    output logic       tx_load,
    output logic [6:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy,
    output logic       ovf
);

    localparam logic [7:0] MAX_B     = 8'(MAX_BURST);
    localparam logic [8:0] MAX_B9    = 9'(MAX_BURST);
    localparam logic [6:0] ADDR_STEP = (AUTO_INC != 0) ? 7'd1 : 7'd0;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CMD     = 3'd1,
        WR      = 3'd2,
        RD_REQ  = 3'd3,
        RD_CAP  = 3'd4,
        RD_WAIT = 3'd5,
        DROP    = 3'd6
    } state_t;

    state_t     state;
    logic [7:0] byte_cnt;
    // Set once frame_active has been seen low, so a reset mid-frame cannot re-enter that frame.
    logic       armed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            byte_cnt  <= 8'd0;
            armed     <= 1'b0;
            reg_addr  <= 7'd0;
            reg_wdata <= 8'd0;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            tx_data   <= 8'd0;
            tx_load   <= 1'b0;
            busy      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            reg_we  <= 1'b0;
            reg_re  <= 1'b0;
            tx_load <= 1'b0;

            if (!frame_active) begin
                armed <= 1'b1;
            end

            // Post-increment after the write strobe so reg_addr is stable while reg_we is high.
            if (reg_we) begin
                reg_addr <= reg_addr + ADDR_STEP;
            end

            if (state != IDLE && !frame_active) begin
                state <= IDLE;
                busy  <= 1'b0;
                if (state == WR && rx_valid) begin
                    if (byte_cnt < MAX_B) begin
                        reg_we    <= 1'b1;
                        reg_wdata <= rx_data;
                        byte_cnt  <= byte_cnt + 8'd1;
                    end else begin
                        ovf <= 1'b1;
                    end
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (frame_active && armed) begin
                            state    <= CMD;
                            busy     <= 1'b1;
                            byte_cnt <= 8'd0;
                            ovf      <= 1'b0;
                            tx_data  <= 8'h00;
                            tx_load  <= 1'b1;
                        end
                    end
                    CMD: begin
                        if (rx_valid) begin
                            reg_addr <= rx_data[6:0];
                            state    <= rx_data[7] ? RD_REQ : WR;
                        end
                    end
                    WR: begin
                        if (rx_valid) begin
                            if (byte_cnt < MAX_B) begin
                                reg_we    <= 1'b1;
                                reg_wdata <= rx_data;
                                byte_cnt  <= byte_cnt + 8'd1;
                            end else begin
                                ovf   <= 1'b1;
                                state <= DROP;
                            end
                        end
                    end
                    RD_REQ: begin
                        reg_re <= 1'b1;
                        state  <= RD_CAP;
                    end
                    RD_CAP: begin
                        tx_data  <= reg_rdata;
                        tx_load  <= 1'b1;
                        reg_addr <= reg_addr + ADDR_STEP;
                        state    <= RD_WAIT;
                    end
                    RD_WAIT: begin
                        // Each dummy byte clocked in pays for the next read.
                        if (rx_valid) begin
                            if (byte_cnt < MAX_B) begin
                                byte_cnt <= byte_cnt + 8'd1;
                            end
                            state <= (({1'b0, byte_cnt} + 9'd1) < MAX_B9) ? RD_REQ : DROP;
                        end
                    end
                    DROP: begin
                        if (rx_valid) begin
                            ovf <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Directed bench for spi_cmd_ctrl: a default instance (burst 16) and a
// short-burst instance (burst 2) share the same SPI-side stimulus.
module tb_spi_cmd_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_active;
    logic       rx_valid;
    logic [7:0] rx_data;

    logic [7:0] a_tx_data, b_tx_data;
    logic       a_tx_load, b_tx_load;
    logic [6:0] a_addr, b_addr;
    logic [7:0] a_wdata, b_wdata;
    logic       a_we, b_we, a_re, b_re;
    logic [7:0] a_rdata, b_rdata;
    logic       a_busy, b_busy, a_ovf, b_ovf;

    int total = 0;
    int bad   = 0;
    int both_cnt = 0;

    logic [6:0] a_we_a[$];
    logic [7:0] a_we_d[$];
    logic [6:0] a_re_a[$];
    logic [7:0] a_tx[$];
    logic [6:0] b_we_a[$];
    logic [7:0] b_we_d[$];
    logic [6:0] b_re_a[$];

    always #5 clk = ~clk;

    // Register file model: read data is the address plus 0x40.
    assign a_rdata = 8'({1'b0, a_addr}) + 8'h40;
    assign b_rdata = 8'({1'b0, b_addr}) + 8'h40;

    spi_cmd_ctrl #(.MAX_BURST(16), .AUTO_INC(1)) u_a (
        .clk(clk), .rst(rst), .frame_active(frame_active),
        .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_data(a_tx_data), .tx_load(a_tx_load),
        .reg_addr(a_addr), .reg_wdata(a_wdata), .reg_we(a_we), .reg_re(a_re),
        .reg_rdata(a_rdata), .busy(a_busy), .ovf(a_ovf)
    );

    spi_cmd_ctrl #(.MAX_BURST(2), .AUTO_INC(1)) u_b (
        .clk(clk), .rst(rst), .frame_active(frame_active),
        .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_data(b_tx_data), .tx_load(b_tx_load),
        .reg_addr(b_addr), .reg_wdata(b_wdata), .reg_we(b_we), .reg_re(b_re),
        .reg_rdata(b_rdata), .busy(b_busy), .ovf(b_ovf)
    );

    always @(negedge clk) begin
        if (a_we) begin a_we_a.push_back(a_addr); a_we_d.push_back(a_wdata); end
        if (a_re) a_re_a.push_back(a_addr);
        if (a_tx_load) a_tx.push_back(a_tx_data);
        if (b_we) begin b_we_a.push_back(b_addr); b_we_d.push_back(b_wdata); end
        if (b_re) b_re_a.push_back(b_addr);
        if ((a_we && a_re) || (b_we && b_re)) both_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        a_we_a.delete(); a_we_d.delete(); a_re_a.delete(); a_tx.delete();
        b_we_a.delete(); b_we_d.delete(); b_re_a.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic start_frame();
        frame_active = 1'b1;
        repeat (3) tick();
    endtask

    task automatic end_frame();
        frame_active = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; frame_active = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) tick();
        total++;
        if ({a_busy, a_ovf, a_we, a_re, a_tx_load} !== 5'b0) begin
            bad++; $display("FAIL reset_flags got=%b exp=00000", {a_busy, a_ovf, a_we, a_re, a_tx_load});
        end
        total++;
        if ({a_addr, a_wdata, a_tx_data} !== 23'd0) begin
            bad++; $display("FAIL reset_regs got addr=%h wdata=%h tx=%h exp all 0", a_addr, a_wdata, a_tx_data);
        end
        rst = 1'b0;
        repeat (2) tick();
        total++;
        if (a_busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b exp=0", a_busy); end
    endtask

    task automatic test_write();
        clear_logs();
        start_frame();
        total++;
        if (a_busy !== 1'b1) begin bad++; $display("FAIL wr_busy got=%b exp=1", a_busy); end
        total++;
        if (a_tx.size() !== 1) begin bad++; $display("FAIL start_txload count got=%0d exp=1", a_tx.size()); end
        else begin
            total++;
            if (a_tx[0] !== 8'h00) begin bad++; $display("FAIL start_txdata got=%h exp=00", a_tx[0]); end
        end
        send_byte(8'h05, 3);
        send_byte(8'hAA, 3);
        send_byte(8'hBB, 3);
        total++;
        if (a_we_a.size() !== 2) begin bad++; $display("FAIL wr_count got=%0d exp=2", a_we_a.size()); end
        else begin
            total++;
            if (a_we_a[0] !== 7'h05 || a_we_d[0] !== 8'hAA) begin
                bad++; $display("FAIL wr0 got=%h/%h exp=05/aa", a_we_a[0], a_we_d[0]);
            end
            total++;
            if (a_we_a[1] !== 7'h06 || a_we_d[1] !== 8'hBB) begin
                bad++; $display("FAIL wr1 got=%h/%h exp=06/bb", a_we_a[1], a_we_d[1]);
            end
        end
        total++;
        if (a_re_a.size() !== 0) begin bad++; $display("FAIL wr_no_read got=%0d exp=0", a_re_a.size()); end
        total++;
        if (a_ovf !== 1'b0) begin bad++; $display("FAIL wr_ovf got=%b exp=0", a_ovf); end
        total++;
        if (a_addr !== 7'h07) begin bad++; $display("FAIL wr_addr_after got=%h exp=07", a_addr); end
        end_frame();
        total++;
        if (a_busy !== 1'b0) begin bad++; $display("FAIL wr_end_busy got=%b exp=0", a_busy); end
    endtask

    task automatic test_read();
        logic [6:0] ea[3] = '{7'h10, 7'h11, 7'h12};
        logic [7:0] et[4] = '{8'h00, 8'h50, 8'h51, 8'h52};
        clear_logs();
        start_frame();
        send_byte(8'h90, 4);
        send_byte(8'h00, 4);
        send_byte(8'h00, 4);
        total++;
        if (a_re_a.size() !== 3) begin bad++; $display("FAIL rd_count got=%0d exp=3", a_re_a.size()); end
        else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (a_re_a[i] !== ea[i]) begin bad++; $display("FAIL rd_addr%0d got=%h exp=%h", i, a_re_a[i], ea[i]); end
            end
        end
        total++;
        if (a_tx.size() !== 4) begin bad++; $display("FAIL rd_txcount got=%0d exp=4", a_tx.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (a_tx[i] !== et[i]) begin bad++; $display("FAIL rd_tx%0d got=%h exp=%h", i, a_tx[i], et[i]); end
            end
        end
        total++;
        if (a_we_a.size() !== 0 || a_ovf !== 1'b0) begin
            bad++; $display("FAIL rd_side got we=%0d ovf=%b exp=0/0", a_we_a.size(), a_ovf);
        end
        end_frame();
    endtask

    task automatic test_overflow();
        clear_logs();
        start_frame();
        send_byte(8'h7F, 3);
        send_byte(8'h11, 3);
        send_byte(8'h22, 3);
        total++;
        if (b_ovf !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b exp=0", b_ovf); end
        send_byte(8'h33, 3);
        total++;
        if (b_we_a.size() !== 2) begin bad++; $display("FAIL ovf_wrcount got=%0d exp=2", b_we_a.size()); end
        else begin
            total++;
            if (b_we_a[0] !== 7'h7F || b_we_d[0] !== 8'h11 || b_we_a[1] !== 7'h00 || b_we_d[1] !== 8'h22) begin
                bad++; $display("FAIL ovf_writes got=%h/%h %h/%h exp=7f/11 00/22", b_we_a[0], b_we_d[0], b_we_a[1], b_we_d[1]);
            end
        end
        total++;
        if (b_ovf !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", b_ovf); end
        total++;
        if (a_we_a.size() !== 3 || a_ovf !== 1'b0) begin
            bad++; $display("FAIL ovf_long got we=%0d ovf=%b exp=3/0", a_we_a.size(), a_ovf);
        end
        end_frame();
        total++;
        if (b_ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", b_ovf); end
        clear_logs();
        start_frame();
        total++;
        if (b_ovf !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", b_ovf); end
        send_byte(8'h80, 4);
        send_byte(8'h00, 4);
        send_byte(8'h00, 4);
        send_byte(8'h00, 4);
        total++;
        if (b_re_a.size() !== 2) begin bad++; $display("FAIL rdburst_short got=%0d exp=2", b_re_a.size()); end
        total++;
        if (a_re_a.size() !== 4) begin bad++; $display("FAIL rdburst_long got=%0d exp=4", a_re_a.size()); end
        total++;
        if (b_ovf !== 1'b1 || a_ovf !== 1'b0) begin
            bad++; $display("FAIL rdburst_ovf got b=%b a=%b exp=1/0", b_ovf, a_ovf);
        end
        end_frame();
    endtask

    task automatic test_abort_rdcap();
        clear_logs();
        start_frame();
        rx_valid = 1'b1; rx_data = 8'h90;
        tick();
        rx_valid = 1'b0;
        tick();
        total++;
        if (a_re !== 1'b1 || a_addr !== 7'h10) begin
            bad++; $display("FAIL abort_re got re=%b addr=%h exp=1/10", a_re, a_addr);
        end
        frame_active = 1'b0;
        tick();
        total++;
        if (a_busy !== 1'b0 || a_tx_load !== 1'b0) begin
            bad++; $display("FAIL abort_idle got busy=%b txl=%b exp=0/0", a_busy, a_tx_load);
        end
        repeat (2) tick();
        total++;
        if (a_tx.size() !== 1) begin bad++; $display("FAIL abort_txcount got=%0d exp=1", a_tx.size()); end
    endtask

    task automatic test_fall_edges();
        clear_logs();
        start_frame();
        send_byte(8'h20, 3);
        rx_valid = 1'b1; rx_data = 8'h77; frame_active = 1'b0;
        tick();
        rx_valid = 1'b0;
        repeat (2) tick();
        total++;
        if (a_we_a.size() !== 1) begin bad++; $display("FAIL fall_wr_count got=%0d exp=1", a_we_a.size()); end
        else begin
            total++;
            if (a_we_a[0] !== 7'h20 || a_we_d[0] !== 8'h77) begin
                bad++; $display("FAIL fall_wr got=%h/%h exp=20/77", a_we_a[0], a_we_d[0]);
            end
        end
        total++;
        if (a_busy !== 1'b0) begin bad++; $display("FAIL fall_wr_busy got=%b exp=0", a_busy); end
        clear_logs();
        start_frame();
        send_byte(8'h85, 4);
        rx_valid = 1'b1; rx_data = 8'h00; frame_active = 1'b0;
        tick();
        rx_valid = 1'b0;
        repeat (4) tick();
        total++;
        if (a_re_a.size() !== 1 || a_tx.size() !== 2) begin
            bad++; $display("FAIL fall_rd got re=%0d tx=%0d exp=1/2", a_re_a.size(), a_tx.size());
        end
    endtask

    task automatic test_back_to_back();
        clear_logs();
        start_frame();
        send_byte(8'h7E, 0);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        send_byte(8'h03, 3);
        total++;
        if (a_we_a.size() !== 3) begin bad++; $display("FAIL b2b_count got=%0d exp=3", a_we_a.size()); end
        else begin
            total++;
            if (a_we_a[0] !== 7'h7E || a_we_a[1] !== 7'h7F || a_we_a[2] !== 7'h00) begin
                bad++; $display("FAIL b2b_addr got=%h %h %h exp=7e 7f 00", a_we_a[0], a_we_a[1], a_we_a[2]);
            end
            total++;
            if (a_we_d[0] !== 8'h01 || a_we_d[1] !== 8'h02 || a_we_d[2] !== 8'h03) begin
                bad++; $display("FAIL b2b_data got=%h %h %h exp=01 02 03", a_we_d[0], a_we_d[1], a_we_d[2]);
            end
        end
        end_frame();
    endtask

    task automatic test_reset_mid();
        clear_logs();
        start_frame();
        send_byte(8'h03, 3);
        rx_valid = 1'b1; rx_data = 8'h44;
        tick();
        rx_valid = 1'b0;
        total++;
        if (a_we !== 1'b1 || a_wdata !== 8'h44) begin
            bad++; $display("FAIL rstmid_pre got we=%b wdata=%h exp=1/44", a_we, a_wdata);
        end
        #1 rst = 1'b1;
        #1;
        total++;
        if ({a_we, a_re, a_tx_load, a_busy, a_ovf} !== 5'b0 || {a_addr, a_wdata, a_tx_data} !== 23'd0) begin
            bad++; $display("FAIL rstmid_async got we=%b busy=%b addr=%h wdata=%h exp all 0", a_we, a_busy, a_addr, a_wdata);
        end
        tick();
        rst = 1'b0;
        clear_logs();
        tick();
        send_byte(8'h55, 2);
        send_byte(8'h66, 2);
        total++;
        if (a_we_a.size() !== 0 || a_busy !== 1'b0 || a_tx.size() !== 0) begin
            bad++; $display("FAIL rstmid_ignore got we=%0d busy=%b tx=%0d exp=0/0/0", a_we_a.size(), a_busy, a_tx.size());
        end
        frame_active = 1'b0;
        tick();
        frame_active = 1'b1;
        repeat (2) tick();
        total++;
        if (a_busy !== 1'b1 || a_tx.size() !== 1) begin
            bad++; $display("FAIL rstmid_reenter got busy=%b tx=%0d exp=1/1", a_busy, a_tx.size());
        end
        end_frame();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_overflow();
        test_abort_rdcap();
        test_fall_edges();
        test_back_to_back();
        test_reset_mid();
        total++;
        if (both_cnt !== 0) begin bad++; $display("FAIL we_re_overlap got=%0d exp=0", both_cnt); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
